// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address, issues valid/ready fetch requests
// and selects the next PC from increment, redirect, trap or a one-entry pending buffer.
module pc_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h10),
   parameter int unsigned     INC       = 4,
   parameter int unsigned     ALIGN     = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            halt,
   input  logic            resume,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_addr,
   input  logic            trap,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus,
   output logic            misalign_err
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN) - 64'd1);

   state_t          state;
   state_t          state_next;
   logic [XLEN-1:0] pc_next;
   logic            held;
   logic            halt_latch;
   logic            halt_latch_next;
   logic            pend_valid;
   logic            pend_valid_next;
   logic            pend_trap;
   logic            pend_trap_next;
   logic [XLEN-1:0] pend_addr;
   logic [XLEN-1:0] pend_addr_next;
   logic            accept;
   logic            waiting;
   logic            redirect_ok;
   logic            redirect_bad;

   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return (addr & ALIGN_MASK) == '0;
   endfunction

   // A held request stays valid regardless of stall so req_addr cannot be withdrawn.
   assign req_valid    = (state == RUN) && (!stall || held);
   assign accept       = req_valid && req_ready;
   assign waiting      = req_valid && !req_ready;
   assign req_addr     = pc;
   assign pc_plus      = pc + INC_W;
   assign redirect_ok  = redirect && is_aligned(redirect_addr);
   assign redirect_bad = redirect && !is_aligned(redirect_addr) && (state != BOOT);

   always_comb begin
      pc_next         = pc;
      pend_valid_next = pend_valid;
      pend_trap_next  = pend_trap;
      pend_addr_next  = pend_addr;
      if (state != BOOT) begin
         if (accept) begin
            if (trap)
               pc_next = TRAP_VEC;
            else if (redirect_ok)
               pc_next = redirect_addr;
            else if (pend_valid)
               pc_next = pend_addr;
            else
               pc_next = pc_plus;
            pend_valid_next = 1'b0;
         end else if (waiting) begin
            // A buffered trap is sticky; a buffered redirect may be replaced.
            if (trap) begin
               pend_valid_next = 1'b1;
               pend_trap_next  = 1'b1;
               pend_addr_next  = TRAP_VEC;
            end else if (redirect_ok && !(pend_valid && pend_trap)) begin
               pend_valid_next = 1'b1;
               pend_trap_next  = 1'b0;
               pend_addr_next  = redirect_addr;
            end
         end else begin
            if (trap)
               pc_next = TRAP_VEC;
            else if (redirect_ok)
               pc_next = redirect_addr;
         end
      end
   end

   always_comb begin
      state_next      = state;
      halt_latch_next = halt_latch;
      case (state)
         BOOT: begin
            state_next = RUN;
            if (resume)
               halt_latch_next = 1'b0;
            else if (halt)
               halt_latch_next = 1'b1;
         end
         RUN: begin
            // A halt arriving while a request waits is deferred until it is accepted.
            if (resume) begin
               halt_latch_next = 1'b0;
            end else if (halt || halt_latch) begin
               if (waiting) begin
                  halt_latch_next = 1'b1;
               end else begin
                  state_next      = HALT;
                  halt_latch_next = 1'b0;
               end
            end
         end
         HALT: begin
            halt_latch_next = 1'b0;
            if (resume || trap)
               state_next = RUN;
         end
         default: begin
            state_next      = BOOT;
            halt_latch_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= BOOT;
         pc           <= RESET_VEC;
         held         <= 1'b0;
         halt_latch   <= 1'b0;
         pend_valid   <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_next;
         pc           <= pc_next;
         held         <= waiting;
         halt_latch   <= halt_latch_next;
         pend_valid   <= pend_valid_next;
         misalign_err <= redirect_bad;
      end
   end

   // Pending payload is only meaningful while pend_valid is set.
   always_ff @(posedge clk) begin
      pend_trap <= pend_trap_next;
      pend_addr <= pend_addr_next;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for the main scenarios and a 16-bit
// instance for address wrap and asynchronous reset during a waiting request.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst, stall, halt, resume, redirect, trap, req_ready;
   logic [31:0] redirect_addr;
   logic        req_valid, misalign_err;
   logic [31:0] req_addr, pc, pc_plus;

   logic        w_rst, w_stall, w_halt, w_resume, w_redirect, w_trap, w_req_ready;
   logic [15:0] w_redirect_addr;
   logic        w_req_valid, w_misalign_err;
   logic [15:0] w_req_addr, w_pc, w_pc_plus;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
      .redirect(redirect), .redirect_addr(redirect_addr), .trap(trap),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .pc(pc), .pc_plus(pc_plus), .misalign_err(misalign_err)
   );

   pc_unit #(.XLEN(16), .RESET_VEC(16'hFFFC), .TRAP_VEC(16'h0010)) dut_w (
      .clk(clk), .rst(w_rst), .stall(w_stall), .halt(w_halt), .resume(w_resume),
      .redirect(w_redirect), .redirect_addr(w_redirect_addr), .trap(w_trap),
      .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr(w_req_addr),
      .pc(w_pc), .pc_plus(w_pc_plus), .misalign_err(w_misalign_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h want %h", pc, 32'h0); end
      tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", req_valid); end
      tests++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", misalign_err); end
      rst = 1'b0;
      #1;
      tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL boot_valid got %b want 0", req_valid); end
      tick();
      tests++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin fails++; $display("FAIL first_req got v=%b a=%h want v=1 a=0", req_valid, req_addr); end
      tick();
      tests++; if (req_addr !== 32'h4) begin fails++; $display("FAIL seq_4 got %h want 4", req_addr); end
      tick();
      tests++; if (req_addr !== 32'h8) begin fails++; $display("FAIL seq_8 got %h want 8", req_addr); end
      tick();
      tests++; if (req_addr !== 32'hC || req_valid !== 1'b1) begin fails++; $display("FAIL seq_c got v=%b a=%h want v=1 a=c", req_valid, req_addr); end
      tests++; if (pc_plus !== 32'h10) begin fails++; $display("FAIL pc_plus got %h want 10", pc_plus); end
   endtask

   task automatic test_backpressure_redirect();
      redirect = 1'b1; redirect_addr = 32'h8;
      tick();
      tests++; if (pc !== 32'h8) begin fails++; $display("FAIL redir_accept got %h want 8", pc); end
      redirect_addr = 32'h40; req_ready = 1'b0;
      tick();
      redirect = 1'b0;
      tests++; if (req_addr !== 32'h8 || req_valid !== 1'b1) begin fails++; $display("FAIL wait1 got v=%b a=%h want v=1 a=8", req_valid, req_addr); end
      tick();
      tests++; if (req_addr !== 32'h8) begin fails++; $display("FAIL wait2 got %h want 8", req_addr); end
      tick();
      tests++; if (req_addr !== 32'h8 || req_valid !== 1'b1) begin fails++; $display("FAIL wait3 got v=%b a=%h want v=1 a=8", req_valid, req_addr); end
      req_ready = 1'b1;
      tick();
      tests++; if (req_addr !== 32'h40) begin fails++; $display("FAIL pend_redir got %h want 40", req_addr); end
      tick();
      tests++; if (req_addr !== 32'h44) begin fails++; $display("FAIL after_pend got %h want 44", req_addr); end
   endtask

   task automatic test_priority();
      trap = 1'b1; redirect = 1'b1; redirect_addr = 32'h40;
      tick();
      trap = 1'b0; redirect = 1'b0;
      tests++; if (pc !== 32'h10) begin fails++; $display("FAIL trap_beats_redir got %h want 10", pc); end
      tick();
      tests++; if (pc !== 32'h14) begin fails++; $display("FAIL post_trap_seq got %h want 14", pc); end
      req_ready = 1'b0; trap = 1'b1;
      tick();
      trap = 1'b0; redirect = 1'b1; redirect_addr = 32'h80;
      tests++; if (pc !== 32'h14) begin fails++; $display("FAIL pend_trap_hold got %h want 14", pc); end
      tick();
      redirect = 1'b0; req_ready = 1'b1;
      tests++; if (pc !== 32'h14) begin fails++; $display("FAIL pend_trap_hold2 got %h want 14", pc); end
      tick();
      tests++; if (pc !== 32'h10) begin fails++; $display("FAIL pend_trap_sticky got %h want 10", pc); end
   endtask

   task automatic test_misalign();
      redirect = 1'b1; redirect_addr = 32'h42;
      tick();
      redirect = 1'b0;
      tests++; if (pc !== 32'h14) begin fails++; $display("FAIL misalign_pc got %h want 14", pc); end
      tests++; if (misalign_err !== 1'b1) begin fails++; $display("FAIL misalign_pulse got %b want 1", misalign_err); end
      tick();
      tests++; if (pc !== 32'h18 || misalign_err !== 1'b0) begin fails++; $display("FAIL misalign_end got pc=%h e=%b want 18/0", pc, misalign_err); end
   endtask

   task automatic test_stall_halt();
      req_ready = 1'b0;
      tick();
      stall = 1'b1;
      #1;
      tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL stall_held got %b want 1", req_valid); end
      tick();
      tests++; if (req_valid !== 1'b1 || pc !== 32'h18) begin fails++; $display("FAIL stall_held2 got v=%b pc=%h want 1/18", req_valid, pc); end
      req_ready = 1'b1;
      tick();
      tests++; if (req_valid !== 1'b0 || pc !== 32'h1C) begin fails++; $display("FAIL stall_drop got v=%b pc=%h want 0/1c", req_valid, pc); end
      tick();
      tests++; if (pc !== 32'h1C) begin fails++; $display("FAIL stall_freeze got %h want 1c", pc); end
      stall = 1'b0; halt = 1'b1;
      tick();
      halt = 1'b0;
      tests++; if (req_valid !== 1'b0 || pc !== 32'h20) begin fails++; $display("FAIL halt_enter got v=%b pc=%h want 0/20", req_valid, pc); end
      tick();
      tick();
      tests++; if (req_valid !== 1'b0 || pc !== 32'h20) begin fails++; $display("FAIL halt_frozen got v=%b pc=%h want 0/20", req_valid, pc); end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      tests++; if (req_valid !== 1'b1 || req_addr !== 32'h20) begin fails++; $display("FAIL resume got v=%b a=%h want 1/20", req_valid, req_addr); end
      tick();
      tests++; if (pc !== 32'h24) begin fails++; $display("FAIL resume_seq got %h want 24", pc); end
      req_ready = 1'b0; halt = 1'b1;
      tick();
      halt = 1'b0;
      tests++; if (req_valid !== 1'b1 || pc !== 32'h24) begin fails++; $display("FAIL halt_latched got v=%b pc=%h want 1/24", req_valid, pc); end
      req_ready = 1'b1;
      tick();
      tests++; if (req_valid !== 1'b0 || pc !== 32'h28) begin fails++; $display("FAIL halt_after_acc got v=%b pc=%h want 0/28", req_valid, pc); end
      trap = 1'b1;
      tick();
      trap = 1'b0;
      tests++; if (req_valid !== 1'b1 || pc !== 32'h10) begin fails++; $display("FAIL halt_trap got v=%b pc=%h want 1/10", req_valid, pc); end
      tick();
      tests++; if (pc !== 32'h14) begin fails++; $display("FAIL trap_run_seq got %h want 14", pc); end
   endtask

   task automatic test_wrap_reset();
      w_rst = 1'b0;
      #1;
      tests++; if (w_req_valid !== 1'b0 || w_pc !== 16'hFFFC) begin fails++; $display("FAIL w_boot got v=%b pc=%h want 0/fffc", w_req_valid, w_pc); end
      tick();
      tests++; if (w_req_valid !== 1'b1 || w_req_addr !== 16'hFFFC) begin fails++; $display("FAIL w_first got v=%b a=%h want 1/fffc", w_req_valid, w_req_addr); end
      tests++; if (w_pc_plus !== 16'h0000) begin fails++; $display("FAIL w_pc_plus got %h want 0000", w_pc_plus); end
      tick();
      tests++; if (w_pc !== 16'h0000) begin fails++; $display("FAIL w_wrap got %h want 0000", w_pc); end
      tick();
      w_req_ready = 1'b0;
      tests++; if (w_pc !== 16'h0004) begin fails++; $display("FAIL w_seq got %h want 0004", w_pc); end
      tick();
      #2;
      w_rst = 1'b1;
      #1;
      tests++; if (w_pc !== 16'hFFFC || w_req_valid !== 1'b0) begin fails++; $display("FAIL w_async_rst got pc=%h v=%b want fffc/0", w_pc, w_req_valid); end
      tick();
      w_rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
      redirect = 1'b0; redirect_addr = '0; trap = 1'b0; req_ready = 1'b1;
      w_rst = 1'b1; w_stall = 1'b0; w_halt = 1'b0; w_resume = 1'b0;
      w_redirect = 1'b0; w_redirect_addr = '0; w_trap = 1'b0; w_req_ready = 1'b1;
      test_reset();
      test_backpressure_redirect();
      test_priority();
      test_misalign();
      test_stall_halt();
      test_wrap_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the rv32i data path; successor to the fixed 16-bit PC register. Holds the current fetch address and presents it to instruction memory over a valid/ready request port. Selects the next address from sequential increment, branch/jump redirect or trap vector, and supports stall, halt/resume and misaligned-target rejection. A one-entry pending-redirect buffer keeps the fetch address stable while a request is waiting to be accepted.

## Interface
- XLEN, 32, address width in bits
- RESET_VEC, 0, PC value loaded on reset (XLEN bits)
- TRAP_VEC, 'h10, PC value loaded on trap
- INC, 4, sequential increment
- ALIGN, 2, number of low address bits that must be zero on any redirect target
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  withhold new fetch requests
- halt  in  1  pulse: enter HALT after the current request completes
- resume  in  1  pulse: leave HALT
- redirect  in  1  branch/jump taken this cycle
- redirect_addr  in  XLEN  branch/jump target
- trap  in  1  trap this cycle; target is TRAP_VEC
- req_valid  out  1  fetch request valid
- req_ready  in  1  instruction memory accepts the request
- req_addr  out  XLEN  fetch address (= pc)
- pc  out  XLEN  current PC
- pc_plus  out  XLEN  pc + INC, modulo 2^XLEN (for link register)
- misalign_err  out  1  one-cycle pulse: a redirect target was rejected

## Operation
- States:
  - BOOT: entered on reset; lasts exactly one cycle, then RUN.
  - RUN: issues fetch requests.
  - HALT: req_valid = 0.
- Reset values: pc = RESET_VEC, state = BOOT, req_valid = 0, pending empty, misalign_err = 0.
- Request rule:
  - req_valid = (state == RUN) && (!stall || held).
  - `held` is a register meaning "req_valid was high last cycle and was not accepted".
  - While req_valid && !req_ready, req_addr must not change. stall cannot drop an issued request.
- Accept (req_valid && req_ready) next-PC priority:
  1. trap input → TRAP_VEC
  2. redirect input → redirect_addr
  3. pending entry → its target
  4. otherwise → pc + INC (wraps modulo 2^XLEN)
  - The pending entry is cleared on accept.
- No request outstanding (req_valid = 0, any state except BOOT):
  - trap → TRAP_VEC; redirect → redirect_addr.
  - Both take effect next cycle; otherwise pc holds.
- Request waiting (req_valid && !req_ready):
  - trap or redirect is written into the pending entry (addr, is_trap).
  - Priority when writing: trap beats redirect in the same cycle.
  - A pending trap is never overwritten by a later redirect.
  - A pending redirect is overwritten by a later redirect or trap.
- Misalignment: a redirect with any of redirect_addr[ALIGN-1:0] nonzero is dropped. The drop affects neither pc nor pending, and misalign_err pulses the next cycle. Trap is unaffected.
- Halt:
  - halt in RUN with no request waiting → HALT next cycle.
  - halt with a request waiting → latched; HALT entered the cycle after acceptance.
  - In HALT, resume → RUN; trap → pc = TRAP_VEC and RUN.
  - halt and resume in the same cycle: resume wins.
  - halt in BOOT is latched.
- BOOT ignores redirect and trap.

## Timing
- All outputs are registered or derived combinationally from registers and stall/held.
- pc_plus is combinational from pc.
- Redirect applied with 1-cycle latency: redirect at edge N (with request accepted or no request) → pc = target after edge N.
- Sequential fetch with req_ready tied high and stall low: one request per cycle. pc sequence RESET_VEC, +INC, +2·INC…; first req_valid in the cycle after BOOT.
- Mid-operation rst: on assertion, immediately pc = RESET_VEC, req_valid = 0, pending cleared, halt latch cleared; BOOT is re-entered on release.

## Test plan
- Reset and sequential fetch (XLEN=32, RESET_VEC=0, ready=1): first req_valid 1 cycle after rst release; req_addr 0, 4, 8, 12 on consecutive cycles.
- Backpressure plus redirect: request at 0x8 held with ready=0 for 3 cycles; redirect 0x40 in cycle 1. req_addr stays 0x8 until accept, then 0x40, then 0x44.
- Priority: trap and redirect 0x40 in the same cycle with ready=1 → pc = 0x10. A pending trap followed by redirect 0x80 while waiting → pc = 0x10 after accept.
- Misaligned: redirect_addr 0x42 (ALIGN=2) → pc continues sequentially; misalign_err high for exactly one cycle.
- Stall, halt and resume: stall during an unaccepted request keeps req_valid high until accept, then it drops. halt → req_valid 0 and pc frozen; resume → fetch continues from the frozen pc.
- Wrap and reset mid-run (XLEN=16, pc=0xFFFC): accept → pc = 0x0000. rst asserted mid-wait → pc = RESET_VEC and req_valid = 0 immediately.
